// File: rtl/fib_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fib_sequencer                                             |
// | Brief    : Fibonacci term generator, single-step or prescaled        |
// |            auto-run, valid/ready output, wrap or halt on overflow.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module fib_sequencer #(
    parameter int               WIDTH     = 12,
    parameter int               PRESCALE  = 50000000,
    parameter int               HALT_MODE = 0,
    parameter logic [WIDTH-1:0] SEED0     = '0,
    parameter logic [WIDTH-1:0] SEED1     = WIDTH'(1)
) (
    input  logic             SYSTEM_CLOCK,
    input  logic             RESET_N,
    input  logic             run,
    input  logic             step,
    input  logic             clear,
    output logic [WIDTH-1:0] fib_out,
    output logic [7:0]       fib_index,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic             halted
);

    localparam int                c_ps_w    = $clog2(PRESCALE);
    localparam logic [c_ps_w-1:0] c_ps_last = c_ps_w'(PRESCALE - 1);

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_b_inv;
    logic [7:0]        r_index;
    logic              r_valid;
    logic              r_overflow;
    logic              r_halted;
    logic [c_ps_w-1:0] r_ps;
    logic              r_s1;
    logic              r_s2;
    logic              r_s3;

    logic              w_step_pulse;
    logic              w_active;
    logic              w_tick;
    logic              w_ev;
    logic              w_accept;
    logic              w_handshake;
    logic [WIDTH:0]    w_sum;

    assign w_step_pulse = r_s2 & ~r_s3;
    assign w_active     = run && (r_state == S_RUN);
    assign w_tick       = w_active && (r_ps == c_ps_last);
    assign w_ev         = w_step_pulse | w_tick;
    assign w_handshake  = r_valid && out_ready;
    assign w_accept     = w_ev && (r_state == S_RUN) && (!r_valid || out_ready);
    // One extra bit so the carry flags a successor that no longer fits.
    assign w_sum        = {1'b0, r_a} + {1'b0, r_b};

    always_ff @(posedge SYSTEM_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= S_RUN;
            r_a        <= SEED0;
            r_b        <= SEED1;
            r_b_inv    <= 1'b0;
            r_index    <= 8'd0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
            r_halted   <= 1'b0;
            r_ps       <= '0;
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_s3       <= 1'b0;
        end else begin
            // The synchroniser keeps running through clear so a held step cannot re-fire.
            r_s1 <= step;
            r_s2 <= r_s1;
            r_s3 <= r_s2;

            if (clear) begin
                r_state    <= S_RUN;
                r_a        <= SEED0;
                r_b        <= SEED1;
                r_b_inv    <= 1'b0;
                r_index    <= 8'd0;
                r_valid    <= 1'b0;
                r_overflow <= 1'b0;
                r_halted   <= 1'b0;
                r_ps       <= '0;
            end else begin
                if (w_active) begin
                    r_ps <= (r_ps == c_ps_last) ? '0 : r_ps + c_ps_w'(1);
                end else begin
                    r_ps <= '0;
                end

                if (w_accept) begin
                    if (!r_b_inv) begin
                        r_a     <= r_b;
                        r_b     <= w_sum[WIDTH-1:0];
                        r_b_inv <= w_sum[WIDTH];
                        r_index <= (r_index == 8'hFF) ? r_index : r_index + 8'd1;
                        r_valid <= 1'b1;
                    end else if (HALT_MODE == 0) begin
                        r_a        <= SEED0;
                        r_b        <= SEED1;
                        r_b_inv    <= 1'b0;
                        r_index    <= 8'd0;
                        r_overflow <= 1'b1;
                        r_valid    <= 1'b1;
                    end else begin
                        // No new term; a term taken in this same cycle is still consumed.
                        r_state    <= S_HALT;
                        r_halted   <= 1'b1;
                        r_overflow <= 1'b1;
                        if (w_handshake) begin
                            r_valid <= 1'b0;
                        end
                    end
                end else if (w_handshake) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign fib_out   = r_a;
    assign fib_index = r_index;
    assign out_valid = r_valid;
    assign overflow  = r_overflow;
    assign halted    = r_halted;

endmodule
`default_nettype wire
